// File: rtl/sprite_pkg.sv
// sprite_pkg: shared types and width helper for the sprite animation renderer.
package sprite_pkg;
    typedef enum logic [1:0] {LOOP = 2'd0, ONESHOT = 2'd1, PINGPONG = 2'd2} mode_t;
    typedef enum logic [1:0] {IDLE, PLAY, HOLD} state_t;
    typedef logic [3:0] color_t;

    function automatic int wmin1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/sprite_anim_seq.sv
// sprite_anim_seq: animation state machine with tick and frame counters.
module sprite_anim_seq
    import sprite_pkg::*;
#(
    parameter int NUM_FRAMES  = 4,
    parameter int FRAME_TICKS = 8,
    localparam int FW = wmin1(NUM_FRAMES)
) (
    input  logic          vga_clk,
    input  logic          reset,
    input  logic          frame_start,
    input  logic          trigger,
    input  logic [1:0]    mode,
    output logic [FW-1:0] frame,
    output logic          busy,
    output logic          done
);
    localparam int TW = wmin1(FRAME_TICKS);
    localparam logic [FW-1:0] LAST = FW'(NUM_FRAMES - 1);

    state_t        state, state_n;
    logic [FW-1:0] frame_n, pp_next;
    logic [TW-1:0] tick, tick_n;
    logic          dir, dir_n, pp_dir, wrap;

    always_ff @(posedge vga_clk) begin
        if (reset) begin
            state <= IDLE;
            frame <= '0;
            tick  <= '0;
            dir   <= 1'b0;
        end else begin
            state <= state_n;
            frame <= frame_n;
            tick  <= tick_n;
            dir   <= dir_n;
        end
    end

    // dir=1 means counting down; the ends force the direction so no end frame repeats
    always_comb begin
        wrap    = tick == TW'(FRAME_TICKS - 1);
        pp_dir  = (frame == LAST) ? 1'b1 : (frame == '0) ? 1'b0 : dir;
        pp_next = (LAST == '0) ? '0 : pp_dir ? frame - 1'b1 : frame + 1'b1;
        state_n = state;
        frame_n = frame;
        tick_n  = tick;
        dir_n   = dir;
        if (trigger) begin
            state_n = PLAY;
            frame_n = '0;
            tick_n  = '0;
            dir_n   = 1'b0;
        end else if (state == PLAY && frame_start) begin
            tick_n = wrap ? '0 : tick + 1'b1;
            if (wrap) begin
                if (mode == PINGPONG) begin
                    frame_n = pp_next;
                    dir_n   = pp_dir;
                end else if (mode == ONESHOT) begin
                    frame_n = (frame == LAST) ? frame : frame + 1'b1;
                    state_n = (frame == LAST) ? HOLD : PLAY;
                end else begin
                    frame_n = (frame == LAST) ? '0 : frame + 1'b1;
                end
            end
        end
    end

    assign busy = state == PLAY;
    assign done = state == HOLD;
endmodule

// File: rtl/sprite_anim_renderer.sv
// sprite_anim_renderer: scaled, animated sprite overlay with a 2-cycle ROM/palette pipeline.
module sprite_anim_renderer
    import sprite_pkg::*;
#(
    parameter int SPR_W       = 16,
    parameter int SPR_H       = 16,
    parameter int NUM_FRAMES  = 4,
    parameter int FRAME_TICKS = 8,
    parameter int SCALE_SHIFT = 0,
    parameter int TRANSP_IDX  = 0,
    parameter int ADDR_W      = $clog2(SPR_W * SPR_H * NUM_FRAMES)
) (
    input  logic              vga_clk,
    input  logic              reset,
    input  logic [9:0]        DrawX,
    input  logic [9:0]        DrawY,
    input  logic              blank,
    input  logic              frame_start,
    input  logic [9:0]        pos_x,
    input  logic [9:0]        pos_y,
    input  logic [1:0]        mode,
    input  logic              trigger,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [7:0]        rom_q,
    output logic [7:0]        pal_idx,
    input  color_t            pal_r,
    input  color_t            pal_g,
    input  color_t            pal_b,
    output color_t            red,
    output color_t            green,
    output color_t            blue,
    output logic              opaque,
    output logic              busy,
    output logic              done
);
    localparam int FW = wmin1(NUM_FRAMES);

    logic [FW-1:0]     frame;
    logic [9:0]        px_l, py_l;
    logic [10:0]       dx, dy;
    logic [ADDR_W-1:0] addr_n;
    logic              in_box, in_box0, in_box1, blank0, blank1, vis;

    sprite_anim_seq #(.NUM_FRAMES(NUM_FRAMES), .FRAME_TICKS(FRAME_TICKS)) u_seq (
        .vga_clk(vga_clk), .reset(reset), .frame_start(frame_start), .trigger(trigger),
        .mode(mode), .frame(frame), .busy(busy), .done(done)
    );

    // 11-bit differences wrap negative offsets to large values, so left/above falls outside
    assign dx     = {1'b0, DrawX} - {1'b0, px_l};
    assign dy     = {1'b0, DrawY} - {1'b0, py_l};
    assign in_box = (dx < 11'(SPR_W << SCALE_SHIFT)) && (dy < 11'(SPR_H << SCALE_SHIFT));
    assign addr_n = ADDR_W'(int'(frame) * SPR_W * SPR_H + int'(dy >> SCALE_SHIFT) * SPR_W
                    + int'(dx >> SCALE_SHIFT));
    assign pal_idx = rom_q;
    assign vis     = blank1 && in_box1 && (rom_q != 8'(TRANSP_IDX));

    always_ff @(posedge vga_clk) begin
        if (reset) begin
            px_l     <= '0;
            py_l     <= '0;
            rom_addr <= '0;
            in_box0  <= 1'b0;
            in_box1  <= 1'b0;
            blank0   <= 1'b0;
            blank1   <= 1'b0;
            red      <= '0;
            green    <= '0;
            blue     <= '0;
            opaque   <= 1'b0;
        end else begin
            if (frame_start) begin
                px_l <= pos_x;
                py_l <= pos_y;
            end
            rom_addr <= addr_n;
            in_box0  <= in_box;
            blank0   <= blank;
            in_box1  <= in_box0;
            blank1   <= blank0;
            red      <= vis ? pal_r : '0;
            green    <= vis ? pal_g : '0;
            blue     <= vis ? pal_b : '0;
            opaque   <= vis;
        end
    end
endmodule
